// File: rtl/key_demux_stream.sv
// Keyed stream demultiplexer: routes each input beat to the lowest-indexed port
// whose key matches, else to a default port (or a sink), with a 2-entry FIFO per port.

module kds_fifo #(
    parameter int DATA_LEN = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push_i,
    input  logic                pop_i,
    input  logic [DATA_LEN-1:0] data_i,
    output logic                valid_o,
    output logic                full_o,
    output logic [DATA_LEN-1:0] data_o
);
    logic [1:0]          count_q, count_d;
    logic                wptr_q, rptr_q;
    logic [DATA_LEN-1:0] mem_q [2];

    always_comb begin
        count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            for (int i = 0; i < 2; i++) mem_q[i] <= '0;
        end else begin
            count_q <= count_d;
            if (push_i) begin
                mem_q[wptr_q] <= data_i;
                wptr_q        <= ~wptr_q;
            end
            if (pop_i) rptr_q <= ~rptr_q;
        end
    end

    assign valid_o = (count_q != 2'd0);
    assign full_o  = (count_q == 2'd2);
    assign data_o  = mem_q[rptr_q];
endmodule

module key_demux_stream #(
    parameter int NR_KEY      = 4,
    parameter int KEY_LEN     = 2,
    parameter int DATA_LEN    = 8,
    parameter bit HAS_DEFAULT = 1'b1,
    parameter int CNT_W       = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NR_KEY*KEY_LEN-1:0]  key_list,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [KEY_LEN-1:0]         in_key,
    input  logic [DATA_LEN-1:0]        in_data,
    output logic [NR_KEY-1:0]          out_valid,
    input  logic [NR_KEY-1:0]          out_ready,
    output logic [NR_KEY*DATA_LEN-1:0] out_data,
    output logic                       dflt_valid,
    input  logic                       dflt_ready,
    output logic [DATA_LEN-1:0]        dflt_data,
    output logic [CNT_W-1:0]           miss_cnt,
    output logic                       miss
);
    localparam int NF = NR_KEY + 1;  // slot NR_KEY is the default port

    logic [NF-1:0]                sel_oh, push, pop, full, valid;
    logic [NF-1:0][DATA_LEN-1:0]  head;
    logic                         any_hit, accept;
    logic [CNT_W-1:0]             miss_cnt_q, miss_cnt_d;
    logic                         miss_q, miss_d;

    // Priority select: lowest matching port wins, so duplicate keys never fan out.
    always_comb begin
        sel_oh  = '0;
        any_hit = 1'b0;
        for (int n = 0; n < NR_KEY; n++) begin
            if (!any_hit && (key_list[n*KEY_LEN +: KEY_LEN] == in_key)) begin
                sel_oh[n] = 1'b1;
                any_hit   = 1'b1;
            end
        end
        if (!any_hit) sel_oh[NR_KEY] = 1'b1;
    end

    assign in_ready = ~|(sel_oh & full);
    assign accept   = in_valid && in_ready;
    assign push     = sel_oh & {NF{accept}};

    for (genvar n = 0; n < NR_KEY; n++) begin : g_port
        assign pop[n] = valid[n] && out_ready[n];
        kds_fifo #(.DATA_LEN(DATA_LEN)) u_fifo (
            .clk    (clk),
            .rst_n  (rst_n),
            .push_i (push[n]),
            .pop_i  (pop[n]),
            .data_i (in_data),
            .valid_o(valid[n]),
            .full_o (full[n]),
            .data_o (head[n])
        );
        assign out_valid[n]                       = valid[n];
        assign out_data[n*DATA_LEN +: DATA_LEN]   = head[n];
    end

    if (HAS_DEFAULT) begin : g_dflt
        assign pop[NR_KEY] = valid[NR_KEY] && dflt_ready;
        kds_fifo #(.DATA_LEN(DATA_LEN)) u_fifo (
            .clk    (clk),
            .rst_n  (rst_n),
            .push_i (push[NR_KEY]),
            .pop_i  (pop[NR_KEY]),
            .data_i (in_data),
            .valid_o(valid[NR_KEY]),
            .full_o (full[NR_KEY]),
            .data_o (head[NR_KEY])
        );
    end else begin : g_sink
        // Unmatched beats fall into a sink that never fills.
        assign pop[NR_KEY]   = 1'b0;
        assign valid[NR_KEY] = 1'b0;
        assign full[NR_KEY]  = 1'b0;
        assign head[NR_KEY]  = '0;
    end

    assign dflt_valid = valid[NR_KEY];
    assign dflt_data  = head[NR_KEY];

    always_comb begin
        miss_d     = accept && !any_hit;
        miss_cnt_d = miss_cnt_q;
        if (miss_d && (miss_cnt_q != {CNT_W{1'b1}})) miss_cnt_d = miss_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_cnt_q <= '0;
            miss_q     <= 1'b0;
        end else begin
            miss_cnt_q <= miss_cnt_d;
            miss_q     <= miss_d;
        end
    end

    assign miss_cnt = miss_cnt_q;
    assign miss     = miss_q;
endmodule

// File: tb/tb_key_demux_stream.sv
// Randomized + directed bench for key_demux_stream; two instances (with and
// without default port) share stimulus and are checked against a queue model.

module tb_key_demux_stream;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  key_list;
    logic        in_valid;
    logic [1:0]  in_key;
    logic [7:0]  in_data;
    logic [3:0]  out_ready;
    logic        dflt_ready;

    logic        ir0, ir1, dv0, dv1, ms0, ms1;
    logic [3:0]  ov0, ov1;
    logic [31:0] od0, od1;
    logic [7:0]  dd0, dd1, mc0, mc1;

    int total = 0;
    int bad   = 0;

    logic [7:0] mq [2][5][$];
    int         mcnt [2];
    bit         mexp [2];
    bit         last_acc0;

    always #5 clk = ~clk;

    key_demux_stream #(.NR_KEY(4), .KEY_LEN(2), .DATA_LEN(8), .HAS_DEFAULT(1'b1), .CNT_W(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .key_list(key_list),
        .in_valid(in_valid), .in_ready(ir0), .in_key(in_key), .in_data(in_data),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
        .dflt_valid(dv0), .dflt_ready(dflt_ready), .dflt_data(dd0),
        .miss_cnt(mc0), .miss(ms0)
    );

    key_demux_stream #(.NR_KEY(4), .KEY_LEN(2), .DATA_LEN(8), .HAS_DEFAULT(1'b0), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .key_list(key_list),
        .in_valid(in_valid), .in_ready(ir1), .in_key(in_key), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
        .dflt_valid(dv1), .dflt_ready(dflt_ready), .dflt_data(dd1),
        .miss_cnt(mc1), .miss(ms1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int tgt(input logic [1:0] k, input logic [7:0] kl);
        for (int n = 0; n < 4; n++) if (kl[n*2 +: 2] == k) return n;
        return 4;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            for (int n = 0; n < 5; n++) mq[i][n].delete();
            mcnt[i] = 0;
            mexp[i] = 1'b0;
        end
    endtask

    // Compare both instances against the model mid-cycle, then advance the model
    // across the next rising edge and return #1 after it (input-drive point).
    task automatic step();
        logic       ir [2];
        logic [3:0] ov [2];
        logic [31:0] od [2];
        logic       dv [2];
        logic [7:0] dd [2], mc [2];
        logic       ms [2];
        bit         rdy;
        int         t;
        @(negedge clk);
        ir[0] = ir0; ir[1] = ir1; ov[0] = ov0; ov[1] = ov1; od[0] = od0; od[1] = od1;
        dv[0] = dv0; dv[1] = dv1; dd[0] = dd0; dd[1] = dd1; mc[0] = mc0; mc[1] = mc1;
        ms[0] = ms0; ms[1] = ms1;
        t = tgt(in_key, key_list);
        for (int i = 0; i < 2; i++) begin
            if (t < 4)       rdy = mq[i][t].size() < 2;
            else if (i == 0) rdy = mq[i][4].size() < 2;
            else             rdy = 1'b1;
            chk($sformatf("in_ready%0d", i), ir[i], rdy);
            for (int n = 0; n < 4; n++) begin
                chk($sformatf("out_valid%0d[%0d]", i, n), ov[i][n], mq[i][n].size() != 0);
                if (mq[i][n].size() != 0)
                    chk($sformatf("out_data%0d[%0d]", i, n), od[i][n*8 +: 8], mq[i][n][0]);
            end
            chk($sformatf("dflt_valid%0d", i), dv[i], mq[i][4].size() != 0);
            if (mq[i][4].size() != 0) chk($sformatf("dflt_data%0d", i), dd[i], mq[i][4][0]);
            chk($sformatf("miss_cnt%0d", i), mc[i], mcnt[i]);
            chk($sformatf("miss%0d", i), ms[i], mexp[i]);
            // advance model
            for (int n = 0; n < 4; n++)
                if (mq[i][n].size() != 0 && out_ready[n]) void'(mq[i][n].pop_front());
            if (i == 0 && mq[i][4].size() != 0 && dflt_ready) void'(mq[i][4].pop_front());
            mexp[i] = 1'b0;
            if (in_valid && rdy) begin
                if (t < 4) mq[i][t].push_back(in_data);
                else begin
                    if (i == 0) mq[i][4].push_back(in_data);
                    mexp[i] = 1'b1;
                    if (mcnt[i] < 255) mcnt[i]++;
                end
            end
            if (i == 0) last_acc0 = in_valid && rdy;
        end
        @(posedge clk);
        #1;
    endtask

    // Offer one beat and keep it stable until instance 0 accepts it (bounded).
    task automatic send(input logic [1:0] k, input logic [7:0] d);
        int guard = 0;
        in_valid = 1'b1; in_key = k; in_data = d;
        do begin
            step();
            guard++;
        end while (!last_acc0 && guard < 50);
        if (!last_acc0) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        rst_n = 1'b0; key_list = 8'b11_10_01_00; in_valid = 1'b0; in_key = 2'd2;
        in_data = 8'h00; out_ready = 4'hF; dflt_ready = 1'b1;
        model_clear();
        #2;
        chk("rst_out_valid0", ov0, 0);     chk("rst_out_valid1", ov1, 0);
        chk("rst_out_data0", od0, 0);      chk("rst_dflt_valid0", dv0, 0);
        chk("rst_dflt_data0", dd0, 0);     chk("rst_miss_cnt0", mc0, 0);
        chk("rst_miss0", ms0, 0);          chk("rst_in_ready0", ir0, 1);
        chk("rst_in_ready1", ir1, 1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // routing, all consumers ready
        send(2'd2, 8'hA0); send(2'd0, 8'hA1); send(2'd3, 8'hA2); send(2'd1, 8'hA3);
        idle(3);

        // back-pressure on port 1; third beat must stall until released
        out_ready = 4'b1101;
        send(2'd1, 8'h11); send(2'd1, 8'h22);
        in_valid = 1'b1; in_key = 2'd1; in_data = 8'h33;
        repeat (3) step();
        chk("bp_stall", last_acc0, 0);
        out_ready = 4'hF;
        send(2'd1, 8'h33);
        send(2'd0, 8'h40); send(2'd0, 8'h41);
        idle(3);

        // duplicate keys: only port 0 receives
        key_list = 8'b01_01_01_01;
        send(2'd1, 8'h5A);
        chk("dup_ov", ov0, 4'b0001);
        idle(2);

        // miss to default / sink
        key_list = 8'h00;
        send(2'd3, 8'hEE);
        chk("miss_dflt_valid", dv0, 1);
        chk("miss_dflt_data", dd0, 8'hEE);
        chk("miss_pulse", ms0, 1);
        chk("miss_cnt0_one", mc0, 1);
        chk("miss_cnt1_one", mc1, 1);
        chk("miss_nohit_ov1", ov1, 0);
        idle(2);
        repeat (300) send(2'd3, $urandom_range(0, 255));
        idle(2);
        chk("sat_cnt0", mc0, 8'd255);
        chk("sat_cnt1", mc1, 8'd255);

        // back-to-back push/pop on port 0 at count 1
        key_list = 8'b11_10_01_00;
        for (int i = 1; i <= 10; i++) send(2'd0, i[7:0]);
        idle(3);

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            if (!in_valid || last_acc0) begin
                if ($urandom_range(0, 19) == 0) key_list = 8'($urandom);
                in_valid = ($urandom_range(0, 3) != 0);
                in_key   = 2'($urandom);
                in_data  = 8'($urandom);
            end
            out_ready  = 4'($urandom) | 4'($urandom);
            dflt_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        in_valid = 1'b0; out_ready = 4'hF; dflt_ready = 1'b1;
        idle(3);

        // asynchronous reset mid-operation with ports 0 and 1 full
        key_list = 8'b11_10_01_00; out_ready = 4'h0;
        send(2'd0, 8'h01); send(2'd0, 8'h02); send(2'd1, 8'h03); send(2'd1, 8'h04);
        chk("pre_rst_full", ov0, 4'b0011);
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        chk("mid_rst_ov0", ov0, 0);  chk("mid_rst_ov1", ov1, 0);
        chk("mid_rst_od0", od0, 0);  chk("mid_rst_mc0", mc0, 0);
        chk("mid_rst_ir0", ir0, 1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 4'hF;
        send(2'd0, 8'h77);
        chk("post_rst_data", od0[7:0], 8'h77);
        chk("post_rst_ov", ov0, 4'b0001);
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/key_demux_stream.md
# key_demux_stream

Keyed stream demultiplexer, the write-side counterpart of the key/value selection muxes. It accepts one valid/ready input stream whose beats each carry a key. Each beat is routed to the output port whose configured key matches. Unmatched beats go to a default port or are discarded, and are counted. Every output port has a 2-entry FIFO, so one slow consumer never corrupts ordering on another port.

## Interface
- NR_KEY, 4, number of keyed output ports
- KEY_LEN, 2, key width in bits
- DATA_LEN, 8, payload width in bits
- HAS_DEFAULT, 1, 1: unmatched beats go to the default port; 0: unmatched beats are discarded
- CNT_W, 8, width of miss counter

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- key_list  in  NR_KEY*KEY_LEN  key of port n at bits [KEY_LEN*(n+1)-1 : KEY_LEN*n]; quasi-static configuration
- in_valid  in  1  input beat present
- in_ready  out  1  input beat accepted this cycle when in_valid && in_ready
- in_key  in  KEY_LEN  routing key of current beat
- in_data  in  DATA_LEN  payload of current beat
- out_valid  out  NR_KEY  bit n: port n FIFO head valid
- out_ready  in  NR_KEY  bit n: port n consumer takes head
- out_data  out  NR_KEY*DATA_LEN  port n head payload, same slicing as key_list
- dflt_valid  out  1  default port head valid; constant 0 when HAS_DEFAULT=0
- dflt_ready  in  1  default consumer takes head; ignored when HAS_DEFAULT=0
- dflt_data  out  DATA_LEN  default port head payload
- miss_cnt  out  CNT_W  saturating count of accepted unmatched beats
- miss  out  1  one-cycle pulse, registered, for each accepted unmatched beat

## Operation
- Match: hit[n] = (in_key == key_list slice n). Target is the lowest n with hit[n]=1. Duplicate keys therefore never fan out. This is a deliberate priority rule.
- No hit: the target is the default FIFO when HAS_DEFAULT=1. When HAS_DEFAULT=0 it is a sink that is always ready.
- in_ready = target FIFO count < 2, or 1 for the sink.
  - in_ready is combinational from in_key, key_list and FIFO counts only.
  - in_ready never depends on in_valid or out_ready.
- Push: on in_valid && in_ready, in_data is written to the target FIFO tail. Exactly one FIFO or the sink receives the beat.
- Each FIFO (NR_KEY keyed plus 1 default):
  - 2 entries, count 0..2, separate read and write pointers that wrap mod 2.
  - Pop on out_valid[n] && out_ready[n].
  - out_valid[n] = (count != 0). out_data slice n = entry at read pointer.
- Push and pop on the same FIFO in the same cycle:
  - At count 1: allowed, count stays 1, order is preserved.
  - At count 2: push is blocked because in_ready=0, even if a pop occurs. There is no ready pass-through.
- Miss accounting:
  - An accepted beat with no hit increments miss_cnt, saturating at all-ones. It also raises miss the next cycle.
  - This applies regardless of HAS_DEFAULT.
- Ordering: strict FIFO order per port. There is no ordering guarantee across ports.
- Changing key_list affects only beats accepted after the change. Beats already queued stay in their FIFO.
- Payload values are opaque and never modified.

## Timing
- Reset (rst_n=0, asynchronous):
  - All FIFO counts and pointers are 0; out_valid=0, dflt_valid=0.
  - out_data=0, dflt_data=0 (storage cleared), miss_cnt=0, miss=0.
  - in_ready is still driven combinationally from the empty state: 1 for any key.
  - Reset asserted mid-operation discards all queued beats immediately. No partial pop or push completes.
- Latency: a beat accepted at edge k appears as out_valid=1 after edge k, visible in cycle k+1, if that FIFO was empty.
- Throughput: 1 beat/cycle into a port whose consumer holds out_ready=1.
  - Steady state count is 1. Count reaches 2 only under back-pressure.
- Stall: with out_ready[n]=0, two beats to port n fill its FIFO. The third beat to port n sees in_ready=0.
  - in_valid, in_key and in_data must then be held stable by the producer. The block does not latch them.
- in_ready for a beat to port m is unaffected by port n being full, when m != n.
- miss rises exactly one cycle after the accepting edge and lasts one cycle per miss. Back-to-back misses give a continuous high.

## Test plan
- Reset and routing: NR_KEY=4, key_list = {3,2,1,0} (port n key n). After reset, check out_valid=0 and miss_cnt=0. Send keys 2,0,3,1 with data 8'hA0..8'hA3, all out_ready=1 -> each port asserts out_valid for one cycle, one cycle after acceptance: port2=A0, port0=A1, port3=A2, port1=A3.
- Back-pressure: out_ready[1]=0, send key 1 data 11,22,33 -> first two accepted and in_ready drops on 33. Then release out_ready[1] -> port 1 delivers 11 then 22, and 33 is accepted once count<2. Meanwhile key 0 beats keep flowing.
- Duplicate keys: key_list = {1,1,1,1}, send key 1 data 8'h5A -> only port 0 receives it, out_valid=4'b0001.
- Miss handling:
  - key_list = {0,0,0,0}, HAS_DEFAULT=1, send key 3 data 8'hEE -> dflt_valid with 8'hEE, miss pulse, miss_cnt=1.
  - Rerun with HAS_DEFAULT=0 -> in_ready=1, no port valid, miss_cnt=1.
  - Send 300 misses with CNT_W=8 -> miss_cnt saturates at 255.
- Same-cycle push and pop: port 0 at count 1 with out_ready[0]=1, accept new beat -> count stays 1 and order is preserved over 10 consecutive beats 1..10.
- Reset mid-operation: fill ports 0 and 1 to count 2, assert rst_n=0 between edges -> out_valid clears immediately without a clock edge. After release, the first new beat is delivered and no stale data appears.
